// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage and the instruction decoder.
package cpu_pkg;

  // An all-zero word decodes as a nop, so a bubble on the IF/ID register is simply zero.
  localparam logic [31:0] NOP_INS          = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Opcode and funct fields that the decoder uses to recognise jr.
  localparam logic [5:0] OPCODE_RTYPE = 6'b000000;
  localparam logic [5:0] FUNCT_JR     = 6'b001000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  // Clear the byte-offset bits so that a redirect always lands on a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // True when the word is an R-type jr.
  function automatic logic is_jr_ins(input logic [31:0] word);
    return (word[31:26] == OPCODE_RTYPE) && (word[5:0] == FUNCT_JR);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of signals between the fetch stage and the rest of the core:
// the hazard and jr controls, the instruction memory, and the IF/ID register.
// The fetch stage uses the master modport; the memory, decoder and hazard logic use the slave modport.
interface fetch_stage_if #(
  parameter int CNT_W = 32
);

  logic             stall;
  logic             jr;
  logic [31:0]      jr_target;
  logic [31:0]      imem_data;
  logic [31:0]      imem_addr;
  logic [31:0]      pc;
  logic [31:0]      ins;
  logic [31:0]      ins_pc;
  logic             ins_valid;
  logic             misalign;
  logic [CNT_W-1:0] issued_cnt;

  modport master (
    input  stall, jr, jr_target, imem_data,
    output imem_addr, pc, ins, ins_pc, ins_valid, misalign, issued_cnt
  );

  modport slave (
    output stall, jr, jr_target, imem_data,
    input  imem_addr, pc, ins, ins_pc, ins_valid, misalign, issued_cnt
  );

endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter register and its next-PC selection.
// On each edge the PC does one of three things: it holds, it steps by PC_STEP,
// or it loads the word-aligned jr target. A redirect takes priority over a step.
module fetch_pc_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  input  logic        redirect,
  input  logic [31:0] jr_target,
  output logic [31:0] pc
);

  logic [31:0] pc_next;

  // Next-PC mux. The increment wraps modulo 2^32 and raises no flag.
  always_comb begin
    pc_next = pc;
    if (redirect) begin
      pc_next = word_align(jr_target);
    end else if (advance) begin
      pc_next = pc + 32'(PC_STEP);
    end
  end

  // PC register. Reset takes priority, so any redirect pending at reset is lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage. It presents the PC to the instruction memory and
// registers the returned word into the IF/ID register for the decoder.
// A jr redirect costs exactly one bubble, and the hazard unit can stall the stage.
// The stage also counts every real instruction that is loaded into the IF/ID register.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          PC_STEP  = 4,
  parameter int          CNT_W    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);

  fetch_state_t     state;
  logic [31:0]      pc_w;
  logic [31:0]      ins_q;
  logic [31:0]      ins_pc_q;
  logic             ins_valid_q;
  logic             misalign_q;
  logic [CNT_W-1:0] cnt_q;
  logic             jr_taken;
  logic             advance;

  // A jr is honoured only when it belongs to a real instruction, and it wins over a stall.
  // Because BOOT and FLUSH always hold a bubble, the same rule covers every state.
  always_comb begin
    jr_taken = bus.jr & ins_valid_q;
    advance  = ~jr_taken & ~bus.stall;
  end

  fetch_pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .advance   (advance),
    .redirect  (jr_taken),
    .jr_target (bus.jr_target),
    .pc        (pc_w)
  );

  // Control FSM, IF/ID register, misalign pulse and issued-instruction counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= BOOT;
      ins_q       <= NOP_INS;
      ins_pc_q    <= 32'h0000_0000;
      ins_valid_q <= 1'b0;
      misalign_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      misalign_q <= 1'b0;
      case (state)
        RUN: begin
          if (jr_taken) begin
            ins_q       <= NOP_INS;
            ins_valid_q <= 1'b0;
            ins_pc_q    <= pc_w;
            misalign_q  <= |bus.jr_target[1:0];
            state       <= FLUSH;
          end else if (advance) begin
            ins_q       <= bus.imem_data;
            ins_pc_q    <= pc_w;
            ins_valid_q <= 1'b1;
            cnt_q       <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        BOOT, FLUSH: begin
          if (advance) begin
            ins_q       <= bus.imem_data;
            ins_pc_q    <= pc_w;
            ins_valid_q <= 1'b1;
            cnt_q       <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            state       <= RUN;
          end
        end
        default: begin
          state       <= BOOT;
          ins_q       <= NOP_INS;
          ins_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_addr  = pc_w;
  assign bus.pc         = pc_w;
  assign bus.ins        = ins_q;
  assign bus.ins_pc     = ins_pc_q;
  assign bus.ins_valid  = ins_valid_q;
  assign bus.misalign   = misalign_q;
  assign bus.issued_cnt = cnt_q;

endmodule
